// File: rtl/poly_eval_pipe.sv
// poly_eval_pipe: signed Horner polynomial evaluator, one stage per degree,
// valid/ready streaming and a drain-then-commit run-time coefficient bank.
//
// Ports:
//   clock, reset_n           rising-edge clock, async active-low reset
//   coef_we/sel/data         write one slot of the shadow coefficient bank
//   coef_commit, coef_busy   request shadow->active copy; high while pending
//   in_valid/in_ready/x      input sample stream
//   out_valid/out_ready      output stream handshake
//   y, ovf                   low YW bits of result; result does not fit YW
module poly_eval_pipe #(
  parameter int DEGREE = 3,
  parameter int CW = 4,
  parameter int XW = 4,
  parameter int YW = 13,
  localparam int W = CW + DEGREE * (XW + 1),
  localparam int SW = $clog2(DEGREE + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          coef_we,
  input  logic [SW-1:0] coef_sel,
  input  logic [CW-1:0] coef_data,
  input  logic          coef_commit,
  output logic          coef_busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [YW-1:0] y,
  output logic          ovf
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    COMMIT
  } state_e;

  state_e state_q;
  logic   busy_q;
  logic   live_q;

  logic signed [CW-1:0] shad_q [DEGREE+1];
  logic signed [CW-1:0] shad_d [DEGREE+1];
  logic signed [CW-1:0] act_q  [DEGREE+1];

  logic signed [XW-1:0] x_q   [DEGREE];
  logic [DEGREE:0]      v_q;
  logic signed [W-1:0]  acc_q [1:DEGREE];
  logic signed [W-1:0]  acc_d [1:DEGREE];

  logic adv;
  logic fire;
  logic signed [W-1:0] res;

  // The whole pipe advances as one; a stalled output freezes every stage.
  assign adv      = !v_q[DEGREE] || out_ready;
  assign in_ready = adv && live_q && (state_q == RUN);
  assign fire     = in_valid && in_ready;

  // Horner stage k: acc = prev * x + a[D-k], all at full width W,
  // which is wide enough that no intermediate value can wrap.
  for (genvar k = 1; k <= DEGREE; k++) begin : g_stage
    logic signed [W-1:0] base;
    logic signed [W-1:0] xs;
    logic signed [W-1:0] ak;
    if (k == 1) begin : g_first
      assign base = W'(act_q[DEGREE]);
    end else begin : g_next
      assign base = acc_q[k-1];
    end
    assign xs       = W'(x_q[k-1]);
    assign ak       = W'(act_q[DEGREE-k]);
    assign acc_d[k] = base * xs + ak;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int k = 0; k < DEGREE; k++) begin
        x_q[k] <= '0;
      end
      for (int k = 1; k <= DEGREE; k++) begin
        acc_q[k] <= '0;
      end
    end else if (adv) begin
      v_q    <= {v_q[DEGREE-1:0], fire};
      x_q[0] <= x;
      for (int k = 1; k < DEGREE; k++) begin
        x_q[k] <= x_q[k-1];
      end
      for (int k = 1; k <= DEGREE; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  // Out-of-range slot indices simply match no slot.
  always_comb begin
    for (int i = 0; i <= DEGREE; i++) begin
      shad_d[i] = shad_q[i];
      if (coef_we && coef_sel == SW'(i)) begin
        shad_d[i] = coef_data;
      end
    end
  end

  // Active bank only changes in COMMIT, when the pipe is provably
  // empty, so every sample sees exactly one coefficient set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      busy_q  <= 1'b0;
      live_q  <= 1'b0;
      for (int i = 0; i <= DEGREE; i++) begin
        shad_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      live_q <= 1'b1;
      for (int i = 0; i <= DEGREE; i++) begin
        shad_q[i] <= shad_d[i];
      end
      unique case (state_q)
        RUN: begin
          if (coef_commit) begin
            state_q <= DRAIN;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (v_q == '0) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          for (int i = 0; i <= DEGREE; i++) begin
            act_q[i] <= shad_d[i];
          end
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign res       = acc_q[DEGREE];
  assign y         = res[YW-1:0];
  assign ovf       = !((&res[W-1:YW-1]) || !(|res[W-1:YW-1]));
  assign out_valid = v_q[DEGREE];
  assign coef_busy = busy_q;

endmodule

// File: tb/tb_poly_eval_pipe.sv
// tb_poly_eval_pipe: directed and randomized checks of poly_eval_pipe
// against a power-sum reference model with a coefficient-bank model.
module tb_poly_eval_pipe;

  localparam int DEG = 3;
  localparam int CW = 4;
  localparam int XW = 4;
  localparam int YW = 13;
  localparam int SW = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          coef_we = 1'b0;
  logic [SW-1:0] coef_sel = '0;
  logic [CW-1:0] coef_data = '0;
  logic          coef_commit = 1'b0;
  logic          coef_busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] x = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [YW-1:0] y;
  logic          ovf;

  poly_eval_pipe #(
    .DEGREE(DEG), .CW(CW), .XW(XW), .YW(YW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .coef_we(coef_we), .coef_sel(coef_sel),
    .coef_data(coef_data), .coef_commit(coef_commit),
    .coef_busy(coef_busy),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint yv;
    logic   ov;
  } exp_t;

  exp_t q[$];
  int   sh_m [DEG+1];
  int   ac_m [DEG+1];
  bit   pend_m;
  int   n_acc;
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: sum of a[i]*x^i with the bank active at accept time.
  function automatic longint poly(input longint xv);
    longint s = 0;
    longint p = 1;
    for (int i = 0; i <= DEG; i++) begin
      s += longint'(ac_m[i]) * p;
      p *= xv;
    end
    return s;
  endfunction

  function automatic exp_t mk_exp(input longint full);
    exp_t e;
    logic [63:0] f;
    longint lim;
    f = full;
    lim = longint'(1) <<< (YW - 1);
    e.yv = longint'($signed(f[YW-1:0]));
    e.ov = (full > lim - 1) || (full < -lim);
    return e;
  endfunction

  // Compare process: sampled on negedge, i.e. what the next edge does.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        q.delete();
        pend_m = 1'b0;
        for (int i = 0; i <= DEG; i++) begin
          sh_m[i] = 0;
          ac_m[i] = 0;
        end
      end else begin
        if (pend_m && q.size() > 0) begin
          chk("drain_ready", longint'(in_ready), 0);
          chk("drain_busy", longint'(coef_busy), 1);
        end
        if (out_valid && !out_ready) begin
          chk("stall_ready", longint'(in_ready), 0);
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("spurious_out", 1, 0);
          end else begin
            e = q[0];
            chk("model_y", longint'($signed(y)), e.yv);
            chk("model_ovf", longint'(ovf), longint'(e.ov));
            if (out_ready) begin
              void'(q.pop_front());
            end
          end
        end
        if (in_valid && in_ready) begin
          if (pend_m) begin
            ac_m = sh_m;
            pend_m = 1'b0;
          end
          q.push_back(mk_exp(poly(longint'($signed(x)))));
          n_acc++;
        end
        if (coef_we && int'(coef_sel) <= DEG) begin
          sh_m[coef_sel] = int'($signed(coef_data));
        end
        if (coef_commit) begin
          pend_m = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int xv);
    int n = 0;
    in_valid = 1'b1;
    x = XW'(xv);
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 100) break;
      cyc();
    end
    if (n > 100) chk("send_timeout", 1, 0);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic get_out(output longint yv, output logic ov);
    int n = 0;
    yv = 0;
    ov = 1'b0;
    forever begin
      @(negedge clock);
      if (out_valid || n > 100) break;
      n++;
      cyc();
    end
    if (!out_valid) begin
      chk("out_timeout", 1, 0);
    end else begin
      yv = longint'($signed(y));
      ov = ovf;
    end
    cyc();
  endtask

  task automatic wr(input int sel, input int d);
    coef_we = 1'b1;
    coef_sel = SW'(sel);
    coef_data = CW'(d);
    cyc();
    coef_we = 1'b0;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    cyc();
    coef_commit = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clock);
      if (!coef_busy || n > 100) break;
      n++;
      cyc();
    end
    if (coef_busy) chk("idle_timeout", 1, 0);
    cyc();
  endtask

  task automatic expect_out(input string nm, input longint ey,
                            input logic eo);
    longint yv;
    logic ov;
    get_out(yv, ov);
    chk({nm, "_y"}, yv, ey);
    chk({nm, "_ovf"}, longint'(ov), longint'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lock;
    int n;
    n_cmp = 0;
    n_bad = 0;
    n_acc = 0;

    // Reset state
    repeat (2) cyc();
    @(negedge clock);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_y", longint'(y), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_busy", longint'(coef_busy), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    cyc();
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_pre_edge", longint'(in_ready), 0);
    cyc();
    @(negedge clock);
    chk("ready_post_edge", longint'(in_ready), 1);
    cyc();

    // Cubic 2x^3-3x^2-5x, latency and one result per clock
    wr(3, 2); wr(2, -3); wr(1, -5); wr(0, 0);
    commit();
    wait_idle();
    send(3); send(-8); send(0);
    @(negedge clock);
    chk("lat_early", longint'(out_valid), 0);
    cyc();
    @(negedge clock);
    chk("lat3_valid", longint'(out_valid), 1);
    chk("cubic_x3", longint'($signed(y)), 12);
    chk("cubic_x3_ovf", longint'(ovf), 0);
    cyc();
    @(negedge clock);
    chk("b2b_valid1", longint'(out_valid), 1);
    chk("cubic_xm8", longint'($signed(y)), -1176);
    cyc();
    @(negedge clock);
    chk("b2b_valid2", longint'(out_valid), 1);
    chk("cubic_x0", longint'($signed(y)), 0);
    cyc();

    // Overflow boundary with a3=-8
    wr(2, 0); wr(1, 0); wr(3, -8);
    commit();
    wait_idle();
    send(-8); send(7);
    expect_out("ovf_xm8", -4096, 1'b1);
    expect_out("ovf_x7", -2744, 1'b0);

    // Backpressure: four samples fill the pipe, then hold
    out_ready = 1'b0;
    send(1); send(2); send(-1); send(0);
    in_valid = 1'b1;
    x = 4'd5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_y_hold", longint'($signed(y)), -8);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    expect_out("bp0", -8, 1'b0);
    expect_out("bp1", -64, 1'b0);
    expect_out("bp2", 8, 1'b0);
    expect_out("bp3", 0, 1'b0);

    // Commit mid-stream: shadow writes alone change nothing
    wr(0, 1); wr(1, 1); wr(2, 1); wr(3, 1);
    fork
      begin
        send(1); send(2); send(3);
        commit();
        @(negedge clock);
        chk("mid_busy", longint'(coef_busy), 1);
        chk("mid_in_ready", longint'(in_ready), 0);
        cyc();
        send(2);
      end
      begin
        expect_out("mid_old1", -8, 1'b0);
        expect_out("mid_old2", -64, 1'b0);
        expect_out("mid_old3", -216, 1'b0);
        expect_out("mid_new", 15, 1'b0);
      end
    join

    // Write+commit same cycle, repeat commit while draining
    fork
      begin
        send(0); send(1);
        coef_we = 1'b1;
        coef_sel = 2'd3;
        coef_data = 4'hE;
        coef_commit = 1'b1;
        cyc();
        coef_we = 1'b0;
        cyc();
        coef_commit = 1'b0;
        send(2);
      end
      begin
        expect_out("wc_old0", 1, 1'b0);
        expect_out("wc_old1", 4, 1'b0);
        expect_out("wc_new", -9, 1'b0);
      end
    join
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("single_commit_busy", longint'(coef_busy), 0);
      cyc();
    end

    // Commit on an empty pipe: two cycles without in_ready
    commit();
    @(negedge clock);
    chk("empty_drain_ready", longint'(in_ready), 0);
    cyc();
    @(negedge clock);
    chk("empty_commit_ready", longint'(in_ready), 0);
    cyc();
    @(negedge clock);
    chk("empty_run_ready", longint'(in_ready), 1);
    cyc();

    // Randomized traffic, writes and commits
    lock = n_acc;
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom % 3) != 0;
      x = XW'($urandom);
      out_ready = ($urandom % 4) != 0;
      coef_we = 1'b0;
      coef_commit = 1'b0;
      if (n_acc > lock) begin
        if ($urandom % 5 == 0) begin
          coef_we = 1'b1;
          coef_sel = SW'($urandom);
          coef_data = CW'($urandom);
        end
        if ($urandom % 30 == 0) coef_commit = 1'b1;
      end
      cyc();
      if (coef_commit) lock = n_acc;
    end
    in_valid = 1'b0;
    coef_we = 1'b0;
    coef_commit = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    chk("rand_drained", longint'(q.size()), 0);

    // Reset mid-stream with samples and a commit in flight
    wr(3, 3); wr(0, 5);
    send(1); send(-2); send(4);
    commit();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_y", longint'(y), 0);
    chk("mid_rst_ovf", longint'(ovf), 0);
    chk("mid_rst_busy", longint'(coef_busy), 0);
    cyc();
    @(negedge clock);
    chk("mid_rst_ready", longint'(in_ready), 0);
    cyc();
    reset_n = 1'b1;
    @(negedge clock);
    chk("rel_ready_pre", longint'(in_ready), 0);
    cyc();
    @(negedge clock);
    chk("rel_ready_post", longint'(in_ready), 1);
    cyc();
    send(5);
    expect_out("post_rst_zero", 0, 1'b0);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
